wait_state_data_memory: RTL and testbench

//  Parametrised data memory for the single-cycle and future multi-cycle CPUs, with configurable wait states.

---
 rtl/wait_state_data_memory_pkg.sv | 27 ++
 rtl/wait_state_data_memory_dmem_array.sv | 29 ++
 rtl/wait_state_data_memory.sv | 183 ++++++++++++++++++
 tb/tb_wait_state_data_memory.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wait_state_data_memory_pkg.sv
// Shared definitions for the wait-state data memory: ControlBus bit
// positions, FSM state encodings and the latched operation type.
package wait_state_data_memory_pkg;

    // ControlBus bit positions; bit 0 carries no meaning for the memory
    localparam int CB_READ  = 1;
    localparam int CB_WRITE = 2;

    // Request sequencing: accept in IDLE, count wait states, complete in DONE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memState_t;

    // Operation captured at accept time
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } memOp_t;

    // A request is only meaningful when exactly one enable is raised
    function automatic logic isSingleRequest(input logic readEn, input logic writeEn);
        return readEn ^ writeEn;
    endfunction

endpackage

// File: rtl/wait_state_data_memory_dmem_array.sv
// Single-port synchronous word array with a write enable and a registered
// read port. Contents are never reset; the owning controller guarantees
// that wordAddr is in range whenever either enable is raised.
module wait_state_data_memory_dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ARRAY_AW   = 10
) (
    input  logic                  clock,
    input  logic                  writeEnable,
    input  logic                  readEnable,
    input  logic [ARRAY_AW-1:0]   wordAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // One shared address; a write and a read never target the same cycle in practice
    always_ff @(posedge clock) begin
        if (writeEnable) begin
            mem[wordAddr] <= writeData;
        end
        if (readEnable) begin
            readData <= mem[wordAddr];
        end
    end

endmodule

// File: rtl/wait_state_data_memory.sv
// Data memory with a configurable number of wait states. A request is
// latched in IDLE, held through WAIT while the wait counter drains, and
// performed in DONE. Ready, read data, the error flag and the access
// counters are all registered at the DONE edge, so they become visible
// together in the cycle after DONE.
module wait_state_data_memory
    import wait_state_data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  InputClk,
    input  logic                  rst,
    input  logic [2:0]            ControlBus,
    input  logic [ADDR_WIDTH-1:0] AddressBus,
    input  logic [DATA_WIDTH-1:0] DataMemoryInput,
    output logic [DATA_WIDTH-1:0] DataMemoryOutput,
    output logic                  MemReady,
    output logic                  MemBusy,
    output logic                  MemError,
    output logic [31:0]           ReadCount,
    output logic [31:0]           WriteCount
);

    localparam int OFFSET_BITS = $clog2(DATA_WIDTH / 8);
    localparam int ARRAY_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0]            WAIT_INIT   = 4'(WAIT_STATES);

    memState_t             state;
    memState_t             nextState;
    logic [3:0]            waitCnt;
    logic [3:0]            nextWaitCnt;

    memOp_t                latchedOp;
    logic [ADDR_WIDTH-1:0] latchedAddr;
    logic [DATA_WIDTH-1:0] latchedData;

    logic                  readReq;
    logic                  writeReq;
    logic                  canAccept;
    logic                  validReq;
    logic                  conflictReq;

    logic [ADDR_WIDTH-1:0] wordIndex;
    logic                  addrFault;
    logic                  doAccess;
    logic                  doWrite;
    logic                  doRead;

    logic                  zeroOutput;
    logic [DATA_WIDTH-1:0] arrayReadData;
    logic                  readyReg;
    logic                  errorReg;
    logic [31:0]           readCnt;
    logic [31:0]           writeCnt;

    logic                  unusedCtrl;

    assign unusedCtrl = ControlBus[0];

    // Request decode. The Ready cycle is excluded so that a request the CPU
    // is still holding while it sees Ready is not taken twice; a request
    // still present one cycle later is a genuinely new access.
    always_comb begin
        readReq     = ControlBus[CB_READ];
        writeReq    = ControlBus[CB_WRITE];
        canAccept   = (state == IDLE) && !readyReg;
        validReq    = canAccept && isSingleRequest(readReq, writeReq);
        conflictReq = canAccept && readReq && writeReq;
    end

    // Address checks on the latched address: word index and alignment bits
    always_comb begin
        wordIndex = latchedAddr >> OFFSET_BITS;
        addrFault = ((latchedAddr & ALIGN_MASK) != '0) || (wordIndex >= DEPTH_LIMIT);
        doAccess  = (state == DONE) && !rst;
        doWrite   = doAccess && (latchedOp == OP_WRITE) && !addrFault;
        doRead    = doAccess && (latchedOp == OP_READ) && !addrFault;
    end

    // Next-state logic: IDLE accepts, WAIT drains the counter, DONE completes
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            IDLE: begin
                if (validReq) begin
                    nextState   = WAIT;
                    nextWaitCnt = WAIT_INIT;
                end
            end
            WAIT: begin
                if (waitCnt == 4'd0) begin
                    nextState = DONE;
                end else begin
                    nextWaitCnt = waitCnt - 4'd1;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge InputClk) begin
        if (rst) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Capture the request at accept time; later bus activity is ignored
    always_ff @(posedge InputClk) begin
        if (rst) begin
            latchedOp   <= OP_READ;
            latchedAddr <= '0;
            latchedData <= '0;
        end else if (validReq) begin
            latchedOp   <= writeReq ? OP_WRITE : OP_READ;
            latchedAddr <= AddressBus;
            latchedData <= DataMemoryInput;
        end
    end

    // Completion side: Ready pulse, sticky error, counters and read-data select
    always_ff @(posedge InputClk) begin
        if (rst) begin
            readyReg   <= 1'b0;
            errorReg   <= 1'b0;
            readCnt    <= 32'd0;
            writeCnt   <= 32'd0;
            zeroOutput <= 1'b1;
        end else begin
            readyReg <= (state == DONE);
            if (conflictReq) begin
                errorReg <= 1'b1;
            end
            if (state == DONE) begin
                if (addrFault) begin
                    errorReg <= 1'b1;
                end
                if (latchedOp == OP_READ) begin
                    readCnt    <= readCnt + 32'd1;
                    zeroOutput <= addrFault;
                end else begin
                    writeCnt <= writeCnt + 32'd1;
                end
            end
        end
    end

    wait_state_data_memory_dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ARRAY_AW   (ARRAY_AW)
    ) dmemArray (
        .clock       (InputClk),
        .writeEnable (doWrite),
        .readEnable  (doRead),
        .wordAddr    (wordIndex[ARRAY_AW-1:0]),
        .writeData   (latchedData),
        .readData    (arrayReadData)
    );

    assign DataMemoryOutput = zeroOutput ? '0 : arrayReadData;
    assign MemReady         = readyReg;
    assign MemBusy          = (state != IDLE);
    assign MemError         = errorReg;
    assign ReadCount        = readCnt;
    assign WriteCount       = writeCnt;

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Directed bench for the wait-state data memory. Two instances share the
// clock and reset: one with two wait states, one with none. Expected
// values below are worked out by hand from the intended timing.
module tb_wait_state_data_memory;

    logic        clk;
    logic        rst;

    logic [2:0]  sCtrl;
    logic [31:0] sAddr;
    logic [31:0] sWdata;
    logic [31:0] sRdata;
    logic        sReady;
    logic        sBusy;
    logic        sError;
    logic [31:0] sReadCnt;
    logic [31:0] sWriteCnt;

    logic [2:0]  fCtrl;
    logic [31:0] fAddr;
    logic [31:0] fWdata;
    logic [31:0] fRdata;
    logic        fReady;
    logic        fBusy;
    logic        fError;
    logic [31:0] fReadCnt;
    logic [31:0] fWriteCnt;

    int compareCount;
    int mismatchCount;

    localparam logic [2:0] CB_IDLE  = 3'b000;
    localparam logic [2:0] CB_RD    = 3'b010;
    localparam logic [2:0] CB_WR    = 3'b100;
    localparam logic [2:0] CB_BOTH  = 3'b110;

    wait_state_data_memory #(
        .DATA_WIDTH (32), .ADDR_WIDTH (32), .DEPTH (1024), .WAIT_STATES (2)
    ) dutSlow (
        .InputClk         (clk),
        .rst              (rst),
        .ControlBus       (sCtrl),
        .AddressBus       (sAddr),
        .DataMemoryInput  (sWdata),
        .DataMemoryOutput (sRdata),
        .MemReady         (sReady),
        .MemBusy          (sBusy),
        .MemError         (sError),
        .ReadCount        (sReadCnt),
        .WriteCount       (sWriteCnt)
    );

    wait_state_data_memory #(
        .DATA_WIDTH (32), .ADDR_WIDTH (32), .DEPTH (1024), .WAIT_STATES (0)
    ) dutFast (
        .InputClk         (clk),
        .rst              (rst),
        .ControlBus       (fCtrl),
        .AddressBus       (fAddr),
        .DataMemoryInput  (fWdata),
        .DataMemoryOutput (fRdata),
        .MemReady         (fReady),
        .MemBusy          (fBusy),
        .MemError         (fError),
        .ReadCount        (fReadCnt),
        .WriteCount       (fWriteCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic getReady(input bit fast);
        return fast ? fReady : sReady;
    endfunction

    function automatic logic getBusy(input bit fast);
        return fast ? fBusy : sBusy;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic driveBus(input bit fast, input logic [2:0] cb, input logic [31:0] addr, input logic [31:0] data);
        if (fast) begin
            fCtrl  = cb;
            fAddr  = addr;
            fWdata = data;
        end else begin
            sCtrl  = cb;
            sAddr  = addr;
            sWdata = data;
        end
    endtask

    // Present a request in the next cycle and hold it until Ready is seen.
    // latency counts rising edges after the accept edge; -1 means no Ready.
    task automatic applyStimulus(input bit fast, input logic [2:0] cb, input logic [31:0] addr,
                                 input logic [31:0] data, output int latency, output int busyCycles);
        @(negedge clk);
        driveBus(fast, cb, addr, data);
        latency    = -1;
        busyCycles = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (getBusy(fast)) busyCycles++;
            if (getReady(fast)) begin
                latency = i - 1;
                break;
            end
        end
        driveBus(fast, CB_IDLE, 32'h0, 32'h0);
    endtask

    initial begin
        int  latency;
        int  busyCycles;
        bit  sawReady;

        compareCount  = 0;
        mismatchCount = 0;
        rst = 1'b1;
        driveBus(1'b0, CB_IDLE, 32'h0, 32'h0);
        driveBus(1'b1, CB_IDLE, 32'h0, 32'h0);

        // Reset held for two cycles: every output reads zero
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_slow_data",  sRdata,    32'h0);
        checkOutput("rst_slow_ready", 32'(sReady), 32'h0);
        checkOutput("rst_slow_busy",  32'(sBusy),  32'h0);
        checkOutput("rst_slow_error", 32'(sError), 32'h0);
        checkOutput("rst_slow_rcnt",  sReadCnt,  32'h0);
        checkOutput("rst_slow_wcnt",  sWriteCnt, 32'h0);
        checkOutput("rst_fast_busy",  32'(fBusy),  32'h0);
        checkOutput("rst_fast_data",  fRdata,    32'h0);
        rst = 1'b0;

        // Two wait states: write then read back 0x10
        applyStimulus(1'b0, CB_WR, 32'h10, 32'hDEADBEEF, latency, busyCycles);
        checkOutput("ws2_write_latency", 32'(latency), 32'd4);
        checkOutput("ws2_write_busy",    32'(busyCycles), 32'd4);
        checkOutput("ws2_write_data_unchanged", sRdata, 32'h0);
        @(negedge clk);
        checkOutput("ws2_ready_one_cycle", 32'(sReady), 32'h0);
        applyStimulus(1'b0, CB_RD, 32'h10, 32'h0, latency, busyCycles);
        checkOutput("ws2_read_latency", 32'(latency), 32'd4);
        checkOutput("ws2_read_data",    sRdata,    32'hDEADBEEF);
        checkOutput("ws2_read_count",   sReadCnt,  32'd1);
        checkOutput("ws2_write_count",  sWriteCnt, 32'd1);
        checkOutput("ws2_no_error",     32'(sError), 32'h0);

        // No wait states: seed two words, then back-to-back reads
        applyStimulus(1'b1, CB_WR, 32'h0, 32'h11111111, latency, busyCycles);
        checkOutput("ws0_write0_latency", 32'(latency), 32'd2);
        applyStimulus(1'b1, CB_WR, 32'h4, 32'h22222222, latency, busyCycles);
        checkOutput("ws0_write4_latency", 32'(latency), 32'd2);
        applyStimulus(1'b1, CB_RD, 32'h0, 32'h0, latency, busyCycles);
        checkOutput("ws0_read0_latency", 32'(latency), 32'd2);
        checkOutput("ws0_read0_busy",    32'(busyCycles), 32'd2);
        checkOutput("ws0_read0_idle_not_busy", 32'(fBusy), 32'h0);
        checkOutput("ws0_read0_data",    fRdata, 32'h11111111);
        applyStimulus(1'b1, CB_RD, 32'h4, 32'h0, latency, busyCycles);
        checkOutput("ws0_read4_latency", 32'(latency), 32'd2);
        checkOutput("ws0_read4_idle_not_busy", 32'(fBusy), 32'h0);
        checkOutput("ws0_read4_data",    fRdata, 32'h22222222);
        checkOutput("ws0_read_count",    fReadCnt,  32'd2);
        checkOutput("ws0_write_count",   fWriteCnt, 32'd2);

        // Faulting addresses on the slow instance; word 0 seeded first
        applyStimulus(1'b0, CB_WR, 32'h0, 32'hCAFEF00D, latency, busyCycles);
        checkOutput("seed_word0_latency", 32'(latency), 32'd4);
        applyStimulus(1'b0, CB_RD, 32'h1002, 32'h0, latency, busyCycles);
        checkOutput("bad_read_latency", 32'(latency), 32'd4);
        checkOutput("bad_read_data",    sRdata, 32'h0);
        checkOutput("bad_read_error",   32'(sError), 32'h1);
        checkOutput("bad_read_count",   sReadCnt, 32'd2);
        applyStimulus(1'b0, CB_WR, 32'h1000, 32'h55555555, latency, busyCycles);
        checkOutput("oor_write_latency", 32'(latency), 32'd4);
        checkOutput("oor_write_count",   sWriteCnt, 32'd3);
        checkOutput("oor_write_error_sticky", 32'(sError), 32'h1);
        applyStimulus(1'b0, CB_RD, 32'h0, 32'h0, latency, busyCycles);
        checkOutput("word0_not_aliased", sRdata, 32'hCAFEF00D);
        checkOutput("error_still_sticky", 32'(sError), 32'h1);

        // Both enables on the fast instance: flagged, never performed
        @(negedge clk);
        driveBus(1'b1, CB_BOTH, 32'h0, 32'h0);
        sawReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (fReady || fBusy) sawReady = 1'b1;
        end
        driveBus(1'b1, CB_IDLE, 32'h0, 32'h0);
        checkOutput("conflict_no_ready_or_busy", 32'(sawReady), 32'h0);
        checkOutput("conflict_error",      32'(fError), 32'h1);
        checkOutput("conflict_read_count", fReadCnt,  32'd2);
        checkOutput("conflict_write_count", fWriteCnt, 32'd2);

        // Reset while a write to 0x20 waits: old contents and zero counters survive
        applyStimulus(1'b0, CB_WR, 32'h20, 32'h12345678, latency, busyCycles);
        checkOutput("seed_word20_latency", 32'(latency), 32'd4);
        @(negedge clk);
        driveBus(1'b0, CB_WR, 32'h20, 32'hBADBAD00);
        @(negedge clk);
        checkOutput("abort_busy_before_rst", 32'(sBusy), 32'h1);
        rst = 1'b1;
        driveBus(1'b0, CB_IDLE, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        sawReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (sReady) sawReady = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort_no_ready",  32'(sawReady), 32'h0);
        checkOutput("abort_busy",      32'(sBusy), 32'h0);
        checkOutput("abort_error_clr", 32'(sError), 32'h0);
        checkOutput("abort_read_cnt",  sReadCnt,  32'd0);
        checkOutput("abort_write_cnt", sWriteCnt, 32'd0);
        checkOutput("abort_data_zero", sRdata, 32'h0);
        applyStimulus(1'b0, CB_RD, 32'h20, 32'h0, latency, busyCycles);
        checkOutput("abort_word20_kept", sRdata, 32'h12345678);
        checkOutput("abort_read_latency", 32'(latency), 32'd4);
        checkOutput("after_abort_read_cnt", sReadCnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
